// File: rtl/gauge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gauge_pkg
// Description : Shared constants and sweep state encoding for the servo gauge
//               driver (frame length, pulse base width, position range, slew).
// Revision    : 1.0 - initial release
// ============================================================================
package gauge_pkg;

    localparam int c_PERIOD   = 200;  // ticks per PWM frame (20 ms at 10 kHz)
    localparam int c_MIN_HIGH = 5;    // high ticks at position 0 (0.5 ms)
    localparam int c_MAX_POS  = 20;   // largest legal position
    localparam int c_STEP     = 1;    // largest position change per frame

    // Power-on needle self-test states
    typedef enum logic [1:0] {
        SWEEP_UP   = 2'd0,
        SWEEP_DOWN = 2'd1,
        TRACK      = 2'd2
    } sweep_state_t;

endpackage : gauge_pkg
`default_nettype wire

// File: rtl/servo_pwm_frame.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_frame
// Description : Tick-driven PWM frame counter. Flags the frame wrap, emits a
//               registered one-cycle frame_start pulse and drives the
//               registered PWM output by comparing the next count against the
//               pulse width that will be in force after the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_frame
    import gauge_pkg::*;
#(
    parameter int PERIOD = c_PERIOD,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick_en,
    input  logic             i_gauge_en,
    input  logic [CNT_W-1:0] i_width_next,
    output logic             o_wrap,
    output logic             o_frame_start,
    output logic             o_servo_pwm
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_wrap;
    logic             r_frame_start;
    logic             r_servo_pwm;

    // Wrap detection and next counter value
    always_comb begin
        w_wrap     = i_tick_en && (r_frame_cnt == c_LAST);
        w_cnt_next = r_frame_cnt;
        if (i_tick_en) begin
            w_cnt_next = w_wrap ? '0 : r_frame_cnt + 1'b1;
        end
    end

    // Counter, frame_start pulse and PWM level; PWM only moves on a tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt   <= '0;
            r_frame_start <= 1'b0;
            r_servo_pwm   <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (i_tick_en) begin
                r_frame_cnt <= w_cnt_next;
                r_servo_pwm <= (w_cnt_next < i_width_next) && i_gauge_en;
            end
        end
    end

    assign o_wrap        = w_wrap;
    assign o_frame_start = r_frame_start;
    assign o_servo_pwm   = r_servo_pwm;

endmodule : servo_pwm_frame
`default_nettype wire

// File: rtl/servo_gauge_driver.sv
`default_nettype none
// ============================================================================
// Module      : servo_gauge_driver
// Description : Converts a requested gauge position into a slew-limited hobby
//               servo PWM. Target is clamped and sampled once per frame; the
//               driven position moves toward it by at most STEP per frame.
//               Optional macro GAUGE_SWEEP_EN adds a power-on needle sweep
//               (full scale up, back to zero, then track target_pos).
// Revision    : 1.0 - initial release
// ============================================================================
module servo_gauge_driver
    import gauge_pkg::*;
#(
    parameter int PERIOD   = c_PERIOD,
    parameter int CNT_W    = 8,
    parameter int POS_W    = 5,
    parameter int MAX_POS  = c_MAX_POS,
    parameter int MIN_HIGH = c_MIN_HIGH,
    parameter int STEP     = c_STEP
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic             tick_en,
    input  logic             gauge_en,
    input  logic [POS_W-1:0] target_pos,
    output logic             servo_pwm,
    output logic [POS_W-1:0] cur_pos,
    output logic             at_target,
    output logic             frame_start,
    output logic             sweep_busy
);

    localparam logic [POS_W-1:0] c_MAX_P   = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] c_STEP_P  = POS_W'(STEP);
    localparam logic [CNT_W-1:0] c_MIN_W   = CNT_W'(MIN_HIGH);

    logic [POS_W-1:0] r_cur_pos;
    logic [CNT_W-1:0] r_width;
    logic             r_at_target;

    logic             w_wrap;
    logic             w_step_en;
    logic [POS_W-1:0] w_tgt_clamp;
    logic [POS_W-1:0] w_goal;
    logic [POS_W-1:0] w_pos_next;
    logic [CNT_W-1:0] w_width_next;
    logic             w_busy_next;

    // Position only advances at a frame wrap while the servo is driven
    assign w_step_en   = w_wrap && gauge_en;
    assign w_tgt_clamp = (target_pos > c_MAX_P) ? c_MAX_P : target_pos;

`ifdef GAUGE_SWEEP_EN
    sweep_state_t r_state;
    sweep_state_t w_state_next;

    // Sweep state register; reset starts the self-test
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SWEEP_UP;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Internal goal per sweep phase; external target only honoured in TRACK
    always_comb begin
        w_goal = w_tgt_clamp;
        case (r_state)
            SWEEP_UP:   w_goal = c_MAX_P;
            SWEEP_DOWN: w_goal = '0;
            default:    w_goal = w_tgt_clamp;
        endcase
    end

    // Phase changes once the stepped position reaches the end of each sweep
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SWEEP_UP: begin
                if (w_step_en && (w_pos_next == c_MAX_P)) begin
                    w_state_next = SWEEP_DOWN;
                end
            end
            SWEEP_DOWN: begin
                if (w_step_en && (w_pos_next == '0)) begin
                    w_state_next = TRACK;
                end
            end
            default: w_state_next = TRACK;
        endcase
    end

    assign w_busy_next = (w_state_next != TRACK);
    assign sweep_busy  = (r_state != TRACK);
`else
    assign w_goal      = w_tgt_clamp;
    assign w_busy_next = 1'b0;
    assign sweep_busy  = 1'b0;
`endif

    // Slew limiter: move toward the goal by at most STEP
    always_comb begin
        w_pos_next = r_cur_pos;
        if (w_step_en) begin
            if (w_goal > r_cur_pos) begin
                w_pos_next = ((w_goal - r_cur_pos) > c_STEP_P) ? (r_cur_pos + c_STEP_P) : w_goal;
            end else if (w_goal < r_cur_pos) begin
                w_pos_next = ((r_cur_pos - w_goal) > c_STEP_P) ? (r_cur_pos - c_STEP_P) : w_goal;
            end
        end
    end

    // Width that applies after this edge; the frame module compares against it
    assign w_width_next = w_wrap ? (c_MIN_W + CNT_W'(w_pos_next)) : r_width;

    // Per-frame position, width and at_target registers
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_pos   <= '0;
            r_width     <= c_MIN_W;
            r_at_target <= 1'b0;
        end else if (w_wrap) begin
            r_cur_pos   <= w_pos_next;
            r_width     <= w_width_next;
            r_at_target <= (w_pos_next == w_tgt_clamp) && !w_busy_next;
        end
    end

    servo_pwm_frame #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_frame (
        .clk           (clk_100mhz),
        .rst_n         (rst_n),
        .i_tick_en     (tick_en),
        .i_gauge_en    (gauge_en),
        .i_width_next  (w_width_next),
        .o_wrap        (w_wrap),
        .o_frame_start (frame_start),
        .o_servo_pwm   (servo_pwm)
    );

    assign cur_pos   = r_cur_pos;
    assign at_target = r_at_target;

endmodule : servo_gauge_driver
`default_nettype wire

// File: tb/tb_servo_gauge_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_gauge_driver
// Description : Scoreboard bench for servo_gauge_driver. The stimulus process
//               runs a frame-level reference model and queues the expected
//               position, flags and high-tick count for every frame; a
//               separate monitor pops and compares on each frame_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_gauge_driver;

    localparam int c_PER  = 200;
    localparam int c_MAXP = 20;
    localparam int c_MINH = 5;

    logic       clk_100mhz;
    logic       rst_n;
    logic       tick_en;
    logic       gauge_en;
    logic [4:0] target_pos;
    logic       servo_pwm;
    logic [4:0] cur_pos;
    logic       at_target;
    logic       frame_start;
    logic       sweep_busy;

    typedef struct {
        int pos;
        int at;
        int busy;
        int high;
    } exp_t;

    exp_t q_exp[$];
    int   checks;
    int   errors;
    int   frames_seen;
    bit   mon_on;

    servo_gauge_driver dut (
        .clk_100mhz  (clk_100mhz),
        .rst_n       (rst_n),
        .tick_en     (tick_en),
        .gauge_en    (gauge_en),
        .target_pos  (target_pos),
        .servo_pwm   (servo_pwm),
        .cur_pos     (cur_pos),
        .at_target   (at_target),
        .frame_start (frame_start),
        .sweep_busy  (sweep_busy)
    );

    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: frame-level arithmetic straight from the rules
    // ------------------------------------------------------------------
    int m_pos;
    int m_phase;   // 0 = sweeping up, 1 = sweeping down, 2 = tracking

    function automatic exp_t model_wrap(input int tgt_raw, input bit en);
        exp_t e;
        int   tgt;
        int   goal;
        tgt  = (tgt_raw > c_MAXP) ? c_MAXP : tgt_raw;
        goal = (m_phase == 0) ? c_MAXP : ((m_phase == 1) ? 0 : tgt);
        if (en) begin
            if (m_pos < goal)      m_pos = m_pos + 1;
            else if (m_pos > goal) m_pos = m_pos - 1;
            if (m_phase == 0 && m_pos == c_MAXP) m_phase = 1;
            else if (m_phase == 1 && m_pos == 0) m_phase = 2;
        end
        e.pos  = m_pos;
        e.busy = (m_phase != 2) ? 1 : 0;
        e.at   = (e.busy == 0 && m_pos == tgt) ? 1 : 0;
        e.high = en ? (c_MINH + m_pos) : 0;
        return e;
    endfunction

    task automatic one_tick();
        @(negedge clk_100mhz);
        tick_en = 1'b1;
        @(negedge clk_100mhz);
        tick_en = 1'b0;
    endtask

    task automatic wrap_tick();
        q_exp.push_back(model_wrap(int'(target_pos), gauge_en));
        one_tick();
    endtask

    // ------------------------------------------------------------------
    // Monitor: count PWM high ticks per frame, compare at every frame_start
    // ------------------------------------------------------------------
    initial begin : monitor
        int   cnt_high;
        int   exp_high;
        bit   have_win;
        bit   t;
        exp_t e;
        cnt_high = 0;
        exp_high = 0;
        have_win = 1'b0;
        forever begin
            @(posedge clk_100mhz);
            t = tick_en;
            #1;
            if (mon_on && rst_n) begin
                if (frame_start) begin
                    if (have_win) check("frame_high_ticks", cnt_high, exp_high);
                    if (q_exp.size() == 0) begin
                        check("unexpected_frame_start", 1, 0);
                    end else begin
                        e = q_exp.pop_front();
                        check("cur_pos", int'(cur_pos), e.pos);
                        check("at_target", int'(at_target), e.at);
                        check("sweep_busy", int'(sweep_busy), e.busy);
                        exp_high = e.high;
                        have_win = 1'b1;
                    end
                    cnt_high = int'(servo_pwm);
                    frames_seen++;
                end else if (t) begin
                    cnt_high += int'(servo_pwm);
                end
            end
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int n_frames;
        int new_tgt;
        bit mid_change;
        checks      = 0;
        errors      = 0;
        frames_seen = 0;
        mon_on      = 1'b0;
        tick_en     = 1'b0;
        gauge_en    = 1'b1;
        target_pos  = 5'd20;
        m_pos       = 0;
`ifdef GAUGE_SWEEP_EN
        m_phase     = 0;
`else
        m_phase     = 2;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        check("reset_servo_pwm", int'(servo_pwm), 0);
        check("reset_cur_pos", int'(cur_pos), 0);
        check("reset_at_target", int'(at_target), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_sweep_busy", int'(sweep_busy), (m_phase != 2) ? 1 : 0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Counter goes 0 -> 199 before the first wrap
        for (int i = 0; i < c_PER - 1; i++) one_tick();

        n_frames = 86;
        for (int f = 0; f <= n_frames; f++) begin
            mid_change = 1'b0;
            new_tgt    = 0;
            if (f < 22) begin
                target_pos = 5'd20; gauge_en = 1'b1;
            end else if (f < 40) begin
                target_pos = 5'd5;  gauge_en = 1'b1;
            end else if (f < 46) begin
                target_pos = 5'd31; gauge_en = 1'b1;
                if (f == 44) begin mid_change = 1'b1; new_tgt = 19; end
            end else if (f < 49) begin
                gauge_en = 1'b0;
            end else if (f < 50) begin
                target_pos = 5'd31; gauge_en = 1'b1;
            end else if (f < 65) begin
                target_pos = 5'($urandom_range(0, 31));
                gauge_en   = ($urandom_range(0, 4) != 0);
                mid_change = ($urandom_range(0, 2) == 0);
                new_tgt    = int'($urandom_range(0, 31));
            end else begin
                target_pos = 5'd20; gauge_en = 1'b1;
            end
            wrap_tick();
            if (f < n_frames) begin
                for (int i = 1; i < c_PER; i++) begin
                    if (i == 100 && mid_change) target_pos = 5'(new_tgt);
                    one_tick();
                end
            end
        end

        repeat (4) @(negedge clk_100mhz);
        check("frames_seen", frames_seen, n_frames + 1);
        check("queue_drained", q_exp.size(), 0);

        // Asynchronous reset mid-frame while the pulse is high
        mon_on = 1'b0;
        for (int i = 0; i < 10; i++) one_tick();
        check("pre_reset_frame_cnt", int'(dut.u_frame.r_frame_cnt), 10);
        check("pre_reset_servo_pwm", int'(servo_pwm), 1);
        @(posedge clk_100mhz);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_servo_pwm", int'(servo_pwm), 0);
        check("async_reset_cur_pos", int'(cur_pos), 0);
        check("async_reset_frame_cnt", int'(dut.u_frame.r_frame_cnt), 0);
        check("async_reset_at_target", int'(at_target), 0);
`ifdef GAUGE_SWEEP_EN
        check("async_reset_sweep_busy", int'(sweep_busy), 1);
`else
        check("async_reset_sweep_busy", int'(sweep_busy), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_servo_gauge_driver
`default_nettype wire

// File: doc/servo_gauge_driver.md
Name: servo_gauge_driver

Overview:
Downstream consumer of the speed/gear computation stage; converts a requested gauge position into a slew-limited hobby-servo PWM.
- Runs on the 100 MHz system clock, advanced by a single-cycle 10 kHz tick_en strobe from the clock divider.
- Produces a 20 ms frame (200 ticks) whose high time is MIN_HIGH + current position, in ticks.
- Current position moves toward the target by at most STEP per frame, so the needle sweeps smoothly.

Parameters:
- PERIOD, 200: ticks per PWM frame (20 ms at 10 kHz).
- CNT_W, 8: frame counter width; must hold PERIOD-1.
- POS_W, 5: position width.
- MAX_POS, 20: largest legal position; larger targets are clamped.
- MIN_HIGH, 5: high ticks at position 0 (0.5 ms).
- STEP, 1: maximum position change per frame.

Ports:
- clk_100mhz  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tick_en  in  1  one-cycle 10 kHz enable strobe.
- gauge_en  in  1  1 = drive servo, 0 = servo_pwm forced low.
- target_pos  in  POS_W  requested position.
- servo_pwm  out  1  registered PWM output.
- cur_pos  out  POS_W  position currently driven.
- at_target  out  1  cur_pos equals clamped target and sweep_busy = 0.
- frame_start  out  1  one-cycle pulse at each frame wrap.
- sweep_busy  out  1  power-on sweep in progress; tied 0 without the feature.

Behaviour:
- Reset (async, rst_n = 0), all outputs and state cleared immediately, including mid-frame:
  - frame_cnt = 0, cur_pos = 0, width_q = MIN_HIGH.
  - servo_pwm = 0, frame_start = 0, at_target = 0.
  - sweep_busy = 1 with GAUGE_SWEEP_EN, else 0.
- Cycles without tick_en: all state holds; frame_start = 0.
- On tick_en, frame_cnt advances: if frame_cnt == PERIOD-1 it wraps to 0 (wrap event), else it increments.
- Wrap event, all in the same edge:
  - frame_start = 1 for exactly that cycle.
  - tgt_c = min(target_pos, MAX_POS), sampled only here; target changes mid-frame are ignored until the next wrap.
  - cur_pos steps toward tgt_c by min(STEP, |tgt_c - cur_pos|). If equal, no change.
  - width_q <= MIN_HIGH + new cur_pos. The new width first applies to the frame starting at count 0.
- servo_pwm, updated on each tick_en: (next frame_cnt < next width_q) AND gauge_en. Exactly width_q high ticks per frame.
- gauge_en = 0:
  - servo_pwm goes low at the next tick_en.
  - Counter keeps running; cur_pos frozen.
  - Re-enable resumes at the next tick_en.
- at_target is registered and updated at each wrap.
- Width: MIN_HIGH + MAX_POS < PERIOD is guaranteed by parameters; no overflow handling is required.

Optional Feature:
- Macro GAUGE_SWEEP_EN.
- Defined: power-on needle self-test FSM with states SWEEP_UP, SWEEP_DOWN, TRACK.
  - Reset enters SWEEP_UP, with internal target = MAX_POS.
  - SWEEP_UP → SWEEP_DOWN when cur_pos == MAX_POS at a wrap; internal target = 0.
  - SWEEP_DOWN → TRACK when cur_pos == 0 at a wrap.
  - target_pos is ignored until TRACK; sweep_busy = 1 outside TRACK.
  - gauge_en = 0 pauses the sweep (cur_pos frozen).
- Undefined: permanently TRACK; sweep_busy tied 0.

Decomposition:
- Package gauge_pkg holds:
  - Default constants PERIOD, MIN_HIGH, MAX_POS, STEP.
  - The sweep state enum: SWEEP_UP = 0, SWEEP_DOWN = 1, TRACK = 2.
- Sub-module servo_pwm_frame contains the frame counter, the wrap / frame_start generation and the servo_pwm comparator.
- The parent contains the clamp, slew, at_target and sweep FSM.

Test Plan:
- Reset, target 20, gauge_en = 1, feature off, run 4200 ticks → any 200-tick window shows 25 high ticks; cur_pos = 20; at_target = 1.
- From pos 20 set target 5, wait 3000 ticks → 10 high ticks per frame; cur_pos decreases by exactly 1 per frame_start (15 frames).
- Target 31 → clamps to 20, giving 25 high ticks; change target mid-frame (cnt 100) → that frame's width unchanged, next frame's width shifted by 1.
- gauge_en = 0 for 600 ticks → servo_pwm low throughout, cur_pos unchanged; re-enable → 25 high ticks in the next full frame.
- Assert rst_n low at frame_cnt 10 while servo_pwm = 1 → servo_pwm, cur_pos and frame_cnt read 0 immediately, before any clock edge.
- With GAUGE_SWEEP_EN and target 7:
  - sweep_busy = 1 for 40 frames, cur_pos peaking at 20, then 0.
  - sweep_busy falls at 40 frames; cur_pos then reaches 7 after 7 more frames → 12 high ticks.
